// File: rtl/fetch_unit_p_pkg.sv
// Shared types for the instruction-fetch stage: FSM states, redirect sources
// and the redirect priority helper.
package fetch_unit_p_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } fetch_state_e;

  typedef enum logic [2:0] {
    RD_SEQ  = 3'd0,
    RD_JMP  = 3'd1,
    RD_CALL = 3'd2,
    RD_RET  = 3'd3,
    RD_BR   = 3'd4
  } redir_src_e;

  // Redirect priority: taken branch (older instruction) beats every decode
  // redirect; ret beats call/jump; call beats plain jump (same target, push).
  function automatic redir_src_e redirect_sel(input logic br,
                                              input logic ret,
                                              input logic call,
                                              input logic jump);
    redir_src_e sel;
    if (br) begin
      sel = RD_BR;
    end else if (ret) begin
      sel = RD_RET;
    end else if (call) begin
      sel = RD_CALL;
    end else if (jump) begin
      sel = RD_JMP;
    end else begin
      sel = RD_SEQ;
    end
    return sel;
  endfunction

endpackage

// File: rtl/fetch_unit_p_ras_stack.sv
// Return-address stack. Entries live in a circular buffer so that a push onto
// a full stack silently overwrites the oldest entry. Pop on empty is ignored;
// the caller decides what target to use in that case.
module ras_stack
  import fetch_unit_p_pkg::*;
#(
  parameter int RAS_DEPTH = 4,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] entry_q [RAS_DEPTH];
  logic [ADDR_W-1:0] entry_d [RAS_DEPTH];
  logic [PTR_W-1:0]  sp_q, sp_d;
  logic [PTR_W-1:0]  top_idx_s;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Top of stack sits one slot below the write pointer, wrapping at slot 0.
  always_comb begin
    if (sp_q == PTR_ZERO) begin
      top_idx_s = PTR_LAST;
    end else begin
      top_idx_s = sp_q - PTR_ONE;
    end
  end

  // Next-state for storage, write pointer and occupancy count.
  always_comb begin
    entry_d = entry_q;
    sp_d    = sp_q;
    cnt_d   = cnt_q;
    if (clr) begin
      sp_d  = PTR_ZERO;
      cnt_d = CNT_ZERO;
    end else if (push) begin
      entry_d[sp_q] = push_data;
      if (sp_q == PTR_LAST) begin
        sp_d = PTR_ZERO;
      end else begin
        sp_d = sp_q + PTR_ONE;
      end
      if (cnt_q != CNT_FULL) begin
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        cnt_d = cnt_q;
      end
    end else if (pop && (cnt_q != CNT_ZERO)) begin
      sp_d  = top_idx_s;
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      sp_d  = sp_q;
      cnt_d = cnt_q;
    end
  end

  // Stack state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        entry_q[i] <= {ADDR_W{1'b0}};
      end
      sp_q  <= PTR_ZERO;
      cnt_q <= CNT_ZERO;
    end else begin
      entry_q <= entry_d;
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
    end
  end

  assign top   = entry_q[top_idx_s];
  assign empty = (cnt_q == CNT_ZERO);
  assign full  = (cnt_q == CNT_FULL);

endmodule

// File: rtl/fetch_unit_p.sv
// Instruction-fetch stage: program memory with a load path, IDLE/LOAD/RUN
// control, PC selection with branch/call/ret/jump redirects, and a registered
// instruction + address handed to decode.
module fetch_unit_p
  import fetch_unit_p_pkg::*;
#(
  parameter int INSTR_W   = 19,
  parameter int ADDR_W    = 4,
  parameter int RAS_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_en,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic               start,
  input  logic               stall,
  input  logic               jump,
  input  logic               call,
  input  logic               ret,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  output logic               running,
  output logic [ADDR_W:0]    load_count,
  output logic               ras_overflow,
  output logic               ras_underflow
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  // Program memory is deliberately not reset: a reset must not lose a program.
  logic [INSTR_W-1:0] mem_q [DEPTH];

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               instr_valid_q, instr_valid_d;
  logic               running_q, running_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic [CNT_W-1:0]   load_count_q, load_count_d;

  logic               mem_we_s;
  logic [ADDR_W-1:0]  mem_waddr_s;
  logic               enter_load_s, enter_run_s, stay_load_s, stay_run_s;
  redir_src_e         redir_s;
  logic [ADDR_W-1:0]  target_s;
  logic               ras_push_s, ras_pop_s, ras_clr_s;
  logic               ras_empty_s, ras_full_s;
  logic [ADDR_W-1:0]  ras_top_s;

  // FSM next state; load_en takes precedence over start in every state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (load_en) begin
          state_d = ST_LOAD;
        end else if (start) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (!load_en) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (load_en) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State-transition qualifiers used by the datapath.
  always_comb begin
    enter_load_s = (state_q != ST_LOAD) && (state_d == ST_LOAD);
    enter_run_s  = (state_q == ST_IDLE) && (state_d == ST_RUN);
    stay_load_s  = (state_q == ST_LOAD) && (state_d == ST_LOAD);
    stay_run_s   = (state_q == ST_RUN)  && (state_d == ST_RUN);
    running_d    = (state_d == ST_RUN);
  end

  // Redirect source and target. Stall masks decode redirects but not a
  // taken branch, which belongs to an older, unstalled instruction.
  always_comb begin
    if (stay_run_s) begin
      redir_s = redirect_sel(branch_taken, ret & ~stall, call & ~stall, jump & ~stall);
    end else begin
      redir_s = RD_SEQ;
    end
    case (redir_s)
      RD_BR:   target_s = branch_target;
      RD_RET: begin
        if (ras_empty_s) begin
          target_s = ADDR_ZERO;
        end else begin
          target_s = ras_top_s;
        end
      end
      RD_CALL: target_s = jump_target;
      RD_JMP:  target_s = jump_target;
      RD_SEQ:  target_s = pc_q + ADDR_ONE;
      default: target_s = pc_q + ADDR_ONE;
    endcase
  end

  // RAS control: only an un-suppressed call pushes and ret pops.
  always_comb begin
    ras_clr_s  = enter_load_s;
    ras_push_s = (redir_s == RD_CALL);
    ras_pop_s  = (redir_s == RD_RET) && !ras_empty_s;
  end

  // Datapath next state: load pointer, PC, decode register and sticky flags.
  always_comb begin
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    load_count_d  = load_count_q;
    ovf_d         = ovf_q;
    unf_d         = unf_q;
    mem_we_s      = 1'b0;
    mem_waddr_s   = load_count_q[ADDR_W-1:0];
    if (enter_load_s) begin
      load_count_d  = CNT_ZERO;
      instr_valid_d = 1'b0;
      ovf_d         = 1'b0;
      unf_d         = 1'b0;
    end else if (stay_load_s) begin
      if (load_count_q != CNT_MAX) begin
        mem_we_s     = 1'b1;
        load_count_d = load_count_q + CNT_ONE;
      end else begin
        load_count_d = load_count_q;
      end
    end else if (enter_run_s) begin
      pc_d          = ADDR_ZERO;
      instr_valid_d = 1'b0;
    end else if (stay_run_s) begin
      if (!stall) begin
        instr_d       = mem_q[pc_q];
        instr_pc_d    = pc_q;
        instr_valid_d = (redir_s == RD_SEQ);
        pc_d          = target_s;
      end else if (redir_s == RD_BR) begin
        pc_d          = target_s;
        instr_valid_d = 1'b0;
      end else begin
        pc_d          = pc_q;
      end
      if ((redir_s == RD_CALL) && ras_full_s) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
      if ((redir_s == RD_RET) && ras_empty_s) begin
        unf_d = 1'b1;
      end else begin
        unf_d = unf_q;
      end
    end else begin
      pc_d = pc_q;
    end
  end

  // Program memory write port (load path only).
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= load_instr;
    end
  end

  // Control and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= ADDR_ZERO;
      instr_q       <= {INSTR_W{1'b0}};
      instr_pc_q    <= ADDR_ZERO;
      instr_valid_q <= 1'b0;
      running_q     <= 1'b0;
      load_count_q  <= CNT_ZERO;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      running_q     <= running_d;
      load_count_q  <= load_count_d;
      ovf_q         <= ovf_d;
      unf_q         <= unf_d;
    end
  end

  ras_stack #(
    .RAS_DEPTH (RAS_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_ras (
    .clk       (clk),
    .rst_n     (reset),
    .clr       (ras_clr_s),
    .push      (ras_push_s),
    .pop       (ras_pop_s),
    .push_data (instr_pc_q + ADDR_ONE),
    .top       (ras_top_s),
    .empty     (ras_empty_s),
    .full      (ras_full_s)
  );

  assign pc            = pc_q;
  assign instr         = instr_q;
  assign instr_pc      = instr_pc_q;
  assign instr_valid   = instr_valid_q;
  assign running       = running_q;
  assign load_count    = load_count_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule

// File: tb/tb_fetch_unit_p.sv
// Bench for fetch_unit_p: directed scenarios followed by random stimulus,
// every cycle compared against a behavioural model of the fetch stage.
module tb_fetch_unit_p;

  localparam int INSTR_W   = 19;
  localparam int ADDR_W    = 4;
  localparam int RAS_DEPTH = 4;
  localparam int DEPTH     = 16;

  logic               clk;
  logic               reset;
  logic               load_en;
  logic [INSTR_W-1:0] load_instr;
  logic               start;
  logic               stall;
  logic               jump;
  logic               call;
  logic               ret;
  logic [ADDR_W-1:0]  jump_target;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               running;
  logic [ADDR_W:0]    load_count;
  logic               ras_overflow;
  logic               ras_underflow;

  int checks = 0;
  int errors = 0;

  // Behavioural model: mode 0 idle, 1 load, 2 run; RAS as a queue (back = top).
  int                 m_mode;
  logic [INSTR_W-1:0] m_mem [DEPTH];
  int                 m_cnt, m_pc, m_ipc, m_valid, m_ovf, m_unf;
  logic [INSTR_W-1:0] m_instr;
  int                 m_ras [$];

  fetch_unit_p #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_instr(load_instr),
    .start(start), .stall(stall), .jump(jump), .call(call), .ret(ret),
    .jump_target(jump_target), .branch_taken(branch_taken),
    .branch_target(branch_target), .pc(pc), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .running(running), .load_count(load_count),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("pc", 32'(pc), 32'(m_pc));
    check("instr", 32'(instr), 32'(m_instr));
    check("instr_pc", 32'(instr_pc), 32'(m_ipc));
    check("instr_valid", 32'(instr_valid), 32'(m_valid));
    check("running", 32'(running), (m_mode == 2) ? 32'd1 : 32'd0);
    check("load_count", 32'(load_count), 32'(m_cnt));
    check("ras_overflow", 32'(ras_overflow), 32'(m_ovf));
    check("ras_underflow", 32'(ras_underflow), 32'(m_unf));
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_ipc = 0; m_valid = 0; m_cnt = 0;
    m_ovf = 0; m_unf = 0; m_instr = '0;
    m_ras.delete();
  endtask

  task automatic model_enter_load();
    m_cnt = 0; m_valid = 0; m_ovf = 0; m_unf = 0;
    m_ras.delete();
  endtask

  task automatic model_fetch();
    int old_ipc;
    old_ipc = m_ipc;
    if (branch_taken) begin
      if (!stall) begin
        m_instr = m_mem[m_pc];
        m_ipc   = m_pc;
      end
      m_valid = 0;
      m_pc    = int'(branch_target);
    end else if (!stall) begin
      m_instr = m_mem[m_pc];
      m_ipc   = m_pc;
      m_valid = 1;
      if (ret) begin
        m_valid = 0;
        if (m_ras.size() == 0) begin
          m_unf = 1;
          m_pc  = 0;
        end else begin
          m_pc = m_ras.pop_back();
        end
      end else if (call || jump) begin
        m_valid = 0;
        m_pc    = int'(jump_target);
        if (call) begin
          if (m_ras.size() == RAS_DEPTH) begin
            void'(m_ras.pop_front());
            m_ovf = 1;
          end
          m_ras.push_back((old_ipc + 1) % DEPTH);
        end
      end else begin
        m_pc = (m_pc + 1) % DEPTH;
      end
    end
  endtask

  task automatic model_update();
    case (m_mode)
      0: begin
        if (load_en) begin
          m_mode = 1;
          model_enter_load();
        end else if (start) begin
          m_mode  = 2;
          m_pc    = 0;
          m_valid = 0;
        end
      end
      1: begin
        if (!load_en) m_mode = 0;
        else if (m_cnt < DEPTH) begin
          m_mem[m_cnt] = load_instr;
          m_cnt++;
        end
      end
      default: begin
        if (load_en) begin
          m_mode = 1;
          model_enter_load();
        end else begin
          model_fetch();
        end
      end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    if (reset == 1'b0) model_reset();
    else model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic clear_ctl();
    start = 1'b0; stall = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0;
    branch_taken = 1'b0;
  endtask

  task automatic run_until(input int ipc);
    int n;
    n = 0;
    while (!(instr_valid === 1'b1 && int'(instr_pc) == ipc) && n < 40) begin
      step();
      n++;
    end
    check("reach_instr_pc", 32'(instr_pc), 32'(ipc));
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (instr_valid !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    check("wait_valid", 32'(instr_valid), 32'd1);
  endtask

  task automatic load_words(input int n, input int base, input logic rnd);
    load_en = 1'b1;
    step();
    for (int i = 0; i < n; i++) begin
      load_instr = rnd ? INSTR_W'($urandom) : INSTR_W'(base + i);
      step();
    end
    load_en = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; load_en = 1'b0; load_instr = '0; jump_target = '0;
    branch_target = '0;
    clear_ctl();
    model_reset();
    #1 reset = 1'b0;
    @(negedge clk);
    check_all();
    step();
    reset = 1'b1;

    // Fill the whole memory so every address holds a known word.
    load_words(DEPTH, 0, 1'b1);

    // Scenario 1: load 1..5, start, sequential fetch.
    load_words(5, 1, 1'b0);
    check("load_count_5", 32'(load_count), 32'd5);
    start = 1'b1;
    step();
    start = 1'b0;
    check("valid_after_start", 32'(instr_valid), 32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      check("seq_instr", 32'(instr), 32'(k + 1));
      check("seq_instr_pc", 32'(instr_pc), 32'(k));
    end

    // Scenario 2: jump squash, then branch overriding a same-cycle call.
    run_until(2);
    jump = 1'b1; jump_target = 4'd9;
    step();
    clear_ctl();
    check("jump_squash", 32'(instr_valid), 32'd0);
    step();
    check("jump_landed", 32'(instr_pc), 32'd9);
    call = 1'b1; jump_target = 4'd12; branch_taken = 1'b1; branch_target = 4'd3;
    step();
    clear_ctl();
    step();
    check("branch_wins", 32'(instr_pc), 32'd3);

    // Scenario 3: call / ret pair.
    run_until(1);
    call = 1'b1; jump_target = 4'd6;
    step();
    clear_ctl();
    run_until(7);
    ret = 1'b1;
    step();
    clear_ctl();
    step();
    check("ret_resume", 32'(instr_pc), 32'd2);

    // Scenario 4: five nested calls then five rets on a 4-deep RAS.
    for (int i = 0; i < 5; i++) begin
      wait_valid();
      call = 1'b1; jump_target = ADDR_W'(8 + i);
      step();
      clear_ctl();
    end
    check("ras_overflow_set", 32'(ras_overflow), 32'd1);
    for (int i = 0; i < 5; i++) begin
      wait_valid();
      ret = 1'b1;
      step();
      clear_ctl();
    end
    step();
    check("underflow_target", 32'(instr_pc), 32'd0);
    check("ras_underflow_set", 32'(ras_underflow), 32'd1);

    // Scenario 5: stall hold, branch during stall, PC wrap.
    run_until(4);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) step();
    branch_taken = 1'b1; branch_target = 4'd14;
    step();
    check("stall_branch_pc", 32'(pc), 32'd14);
    clear_ctl();
    run_until(15);
    run_until(0);

    // Scenario 6: overlong load, reset mid-run, memory retained.
    load_words(17, 0, 1'b1);
    check("load_saturate", 32'(load_count), 32'd16);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    reset = 1'b0;
    #1;
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_load_count", 32'(load_count), 32'd0);
    model_reset();
    step();
    reset = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20; i++) step();

    // Random phase.
    for (int i = 0; i < 600; i++) begin
      load_en       = ($urandom_range(0, 99) < ((m_mode == 1) ? 80 : 3));
      load_instr    = INSTR_W'($urandom);
      start         = ($urandom_range(0, 99) < 15);
      stall         = ($urandom_range(0, 99) < 20);
      jump          = ($urandom_range(0, 99) < 8);
      call          = ($urandom_range(0, 99) < 8);
      ret           = ($urandom_range(0, 99) < 8);
      branch_taken  = ($urandom_range(0, 99) < 6);
      jump_target   = ADDR_W'($urandom);
      branch_target = ADDR_W'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
